// File: rtl/board_if.sv
// Board controller bus: player status and vsync in, board/transition status out.
interface board_if;
  logic        vsync_in;
  logic [11:0] xpos_L;
  logic [11:0] xpos_R;
  logic        alive_L;
  logic        alive_R;
  logic [2:0]  board;
  logic        trans_busy;
  logic        game_over;
  logic        winner_L;
  logic        winner_R;
  logic        respawn;

  modport master (
    output vsync_in, xpos_L, xpos_R, alive_L, alive_R,
    input  board, trans_busy, game_over, winner_L, winner_R, respawn
  );

  modport slave (
    input  vsync_in, xpos_L, xpos_R, alive_L, alive_R,
    output board, trans_busy, game_over, winner_L, winner_R, respawn
  );
endinterface

// File: rtl/board_ctrl.sv
// Board/level controller: walks players across boards 1..5 on frame ticks,
// runs timed board transitions and the win screen, then restarts the game.
module board_ctrl #(
  parameter int TRANS_FRAMES = 30,
  parameter int OVER_FRAMES  = 300,
  parameter int START_BOARD  = 3
) (
  input  logic   clk,
  input  logic   reset,
  board_if.slave bus
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    TRANS = 2'd1,
    OVER  = 2'd2
  } state_e;

  localparam logic [2:0] START_B    = 3'(START_BOARD);
  localparam logic [8:0] TRANS_LAST = 9'(TRANS_FRAMES - 1);
  localparam logic [8:0] OVER_LAST  = 9'(OVER_FRAMES - 1);

  state_e      state_q, state_d;
  logic [2:0]  board_q, board_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        vs_now_q, vs_now_d;
  logic        vs_prev_q, vs_prev_d;
  logic        trans_busy_q, trans_busy_d;
  logic        game_over_q, game_over_d;
  logic        winner_l_q, winner_l_d;
  logic        winner_r_q, winner_r_d;
  logic        respawn_q, respawn_d;

  logic frame_tick_s;
  logic win_r_s, win_l_s, adv_l_s, adv_r_s;

  // Rising edge of the registered vsync history; one cycle wide by construction.
  assign frame_tick_s = vs_now_q & ~vs_prev_q;

  assign win_r_s = (board_q == 3'd1) && bus.alive_R && (bus.xpos_R < 12'd200);
  assign win_l_s = (board_q == 3'd5) && bus.alive_L && (bus.xpos_L > 12'd760);
  assign adv_l_s = (board_q < 3'd5) && bus.alive_L && !bus.alive_R && (bus.xpos_L >= 12'd960);
  assign adv_r_s = (board_q > 3'd1) && bus.alive_R && !bus.alive_L && (bus.xpos_R < 12'd4);

  // Next-state, board, counter and output computation.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    cnt_d      = cnt_q;
    winner_l_d = winner_l_q;
    winner_r_d = winner_r_q;
    respawn_d  = 1'b0;
    vs_now_d   = bus.vsync_in;
    vs_prev_d  = vs_now_q;

    if (frame_tick_s) begin
      case (state_q)
        PLAY: begin
          if (win_r_s) begin
            state_d    = OVER;
            winner_r_d = 1'b1;
            cnt_d      = 9'd0;
          end else if (win_l_s) begin
            state_d    = OVER;
            winner_l_d = 1'b1;
            cnt_d      = 9'd0;
          end else if (adv_l_s) begin
            state_d = TRANS;
            board_d = board_q + 3'd1;
            cnt_d   = 9'd0;
          end else if (adv_r_s) begin
            state_d = TRANS;
            board_d = board_q - 3'd1;
            cnt_d   = 9'd0;
          end else begin
            state_d = PLAY;
          end
        end
        TRANS: begin
          if (cnt_q == TRANS_LAST) begin
            state_d   = PLAY;
            respawn_d = 1'b1;
            cnt_d     = 9'd0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
        OVER: begin
          if (cnt_q == OVER_LAST) begin
            state_d    = PLAY;
            board_d    = START_B;
            winner_l_d = 1'b0;
            winner_r_d = 1'b0;
            respawn_d  = 1'b1;
            cnt_d      = 9'd0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
        default: begin
          state_d = PLAY;
          cnt_d   = 9'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Status flags follow the next state so they change on the transition edge.
    trans_busy_d = (state_d == TRANS);
    game_over_d  = (state_d == OVER);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PLAY;
      board_q      <= START_B;
      cnt_q        <= 9'd0;
      vs_now_q     <= 1'b0;
      vs_prev_q    <= 1'b0;
      trans_busy_q <= 1'b0;
      game_over_q  <= 1'b0;
      winner_l_q   <= 1'b0;
      winner_r_q   <= 1'b0;
      respawn_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      cnt_q        <= cnt_d;
      vs_now_q     <= vs_now_d;
      vs_prev_q    <= vs_prev_d;
      trans_busy_q <= trans_busy_d;
      game_over_q  <= game_over_d;
      winner_l_q   <= winner_l_d;
      winner_r_q   <= winner_r_d;
      respawn_q    <= respawn_d;
    end
  end

  assign bus.board      = board_q;
  assign bus.trans_busy = trans_busy_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner_L   = winner_l_q;
  assign bus.winner_R   = winner_r_q;
  assign bus.respawn    = respawn_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl: stimulus queues every expected output change
// with the frame number that must cause it; a monitor compares each change.
module tb_board_ctrl;

  logic clk;
  logic reset;

  board_if bif();

  board_ctrl #(
    .TRANS_FRAMES(30),
    .OVER_FRAMES (300),
    .START_BOARD (3)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] v;
    int         t;
  } exp_t;

  exp_t q[$];
  int   tick_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [7:0] vec_s;
  assign vec_s = {bif.board, bif.trans_busy, bif.game_over, bif.winner_L, bif.winner_R, bif.respawn};

  function automatic logic [7:0] mk(input logic [2:0] b, input logic tb, input logic go,
                                    input logic wl, input logic wr, input logic rs);
    return {b, tb, go, wl, wr, rs};
  endfunction

  task automatic push(input logic [7:0] v, input int t);
    exp_t e;
    e.v = v;
    e.t = t;
    q.push_back(e);
  endtask

  task automatic frame();
    tick_cnt++;
    bif.vsync_in = 1'b1;
    repeat (2) @(negedge clk);
    bif.vsync_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One board move: entry on the next frame, respawn 30 frames later.
  task automatic trans_step(input logic [2:0] b_new);
    push(mk(b_new, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), tick_cnt + 1);
    frame();
    push(mk(b_new, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), tick_cnt + 30);
    push(mk(b_new, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), tick_cnt + 30);
    frames(30);
  endtask

  // Monitor: every change of the output vector must match the queue head.
  initial begin
    logic [7:0] prev;
    logic [7:0] cur;
    int         hold;
    exp_t       e;
    prev = 8'bx;
    hold = 0;
    forever begin
      @(posedge clk);
      #1;
      cur = vec_s;
      if (cur !== prev) begin
        if (prev[0] === 1'b1) begin
          n_checks++;
          if (hold == 1) n_pass++;
          else $display("FAIL respawn_width: actual %0d cycles, required 1", hold);
        end
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_change: actual %b at frame %0d, required no change", cur, tick_cnt);
        end else begin
          e = q.pop_front();
          n_checks++;
          if (cur === e.v && tick_cnt == e.t) n_pass++;
          else $display("FAIL out_seq: actual %b at frame %0d, required %b at frame %0d",
                        cur, tick_cnt, e.v, e.t);
        end
        prev = cur;
        hold = 1;
      end else begin
        hold++;
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bif.vsync_in = 1'b0;
    bif.xpos_L   = 12'd0;
    bif.xpos_R   = 12'd0;
    bif.alive_L  = 1'b0;
    bif.alive_R  = 1'b0;
    push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Both alive, left past the edge: no board change for 10 frames.
    bif.alive_L = 1'b1;
    bif.alive_R = 1'b1;
    bif.xpos_L  = 12'd970;
    bif.xpos_R  = 12'd500;
    frames(10);

    // Left advances 3->4; positions stay active during TRANS and are ignored.
    bif.alive_R = 1'b0;
    trans_step(3'd4);

    // 4->5 then reset 10 frames into TRANS: back to board 3, no respawn.
    push(mk(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), tick_cnt + 1);
    frame();
    frames(10);
    push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), tick_cnt);
    do_reset();
    bif.alive_L = 1'b0;
    frames(35);

    // Walk to board 5, left wins there; win screen returns to board 3.
    bif.alive_L = 1'b1;
    bif.xpos_L  = 12'd980;
    trans_step(3'd4);
    trans_step(3'd5);
    push(mk(3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), tick_cnt + 1);
    frame();
    push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), tick_cnt + 300);
    push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), tick_cnt + 300);
    frames(300);

    // Right walks down to board 1; board never goes below 1.
    bif.alive_L = 1'b0;
    bif.alive_R = 1'b1;
    bif.xpos_R  = 12'd2;
    trans_step(3'd2);
    trans_step(3'd1);

    // vsync held high for 1000 cycles yields a single frame; right wins on board 1.
    push(mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), tick_cnt + 1);
    tick_cnt++;
    bif.vsync_in = 1'b1;
    repeat (1000) @(negedge clk);
    bif.vsync_in = 1'b0;
    repeat (2) @(negedge clk);
    push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), tick_cnt + 300);
    push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), tick_cnt + 300);
    frames(300);

    // Back to board 1, then right wins with both players alive.
    trans_step(3'd2);
    trans_step(3'd1);
    bif.alive_L = 1'b1;
    bif.xpos_R  = 12'd150;
    push(mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), tick_cnt + 1);
    frame();
    push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), tick_cnt + 300);
    push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), tick_cnt + 300);
    frames(300);
    bif.alive_L = 1'b0;
    bif.alive_R = 1'b0;
    frames(3);

    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL pending_expect: actual %0d changes not seen, required 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
